// File: rtl/matrix_output_serializer.sv
// Output stage of the 3x3 multiplier datapath: snapshots the nine products and
// streams them LS-byte-first onto an 8-bit valid/ready bus, then raises done.
module matrix_output_serializer #(
  parameter int N_ELEM         = 9,
  parameter int ELEM_W         = 18,
  parameter int BYTES_PER_ELEM = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [N_ELEM*ELEM_W-1:0] c_flat,
  input  logic                     out_ready,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  output logic                     done
);

  localparam int ELEM_IW = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam int BYTE_IW = (BYTES_PER_ELEM > 1) ? $clog2(BYTES_PER_ELEM) : 1;
  localparam int PAD_W   = 8 * BYTES_PER_ELEM;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [N_ELEM*ELEM_W-1:0]   shadow_q, shadow_d;
  logic [ELEM_IW-1:0]         elem_idx_q, elem_idx_d;
  logic [BYTE_IW-1:0]         byte_idx_q, byte_idx_d;
  logic [7:0]                 out_data_q, out_data_d;
  logic                       out_valid_q, out_valid_d;
  logic                       done_q, done_d;
  logic                       last_byte;

  // Bits of the padded element above ELEM_W read back as zero.
  function automatic logic [7:0] pick_byte(input logic [N_ELEM*ELEM_W-1:0] src,
                                           input logic [ELEM_IW-1:0]       e,
                                           input logic [BYTE_IW-1:0]       b);
    logic [PAD_W-1:0] pad;
    pad                = '0;
    pad[ELEM_W-1:0]    = src[e*ELEM_W +: ELEM_W];
    return pad[b*8 +: 8];
  endfunction

  assign last_byte = (elem_idx_q == ELEM_IW'(N_ELEM - 1)) &&
                     (byte_idx_q == BYTE_IW'(BYTES_PER_ELEM - 1));

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    elem_idx_d  = elem_idx_q;
    byte_idx_d  = byte_idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = done_q;

    case (state_q)
      ST_IDLE: begin
        out_valid_d = 1'b0;
        out_data_d  = 8'h00;
        done_d      = 1'b0;
        if (start) begin
          state_d     = ST_SEND;
          shadow_d    = c_flat;
          elem_idx_d  = '0;
          byte_idx_d  = '0;
          out_valid_d = 1'b1;
          out_data_d  = pick_byte(c_flat, '0, '0);
        end
      end

      ST_SEND: begin
        // out_valid is always high here, so out_ready alone marks a transfer.
        if (out_ready) begin
          if (last_byte) begin
            state_d     = ST_DONE;
            elem_idx_d  = '0;
            byte_idx_d  = '0;
            out_valid_d = 1'b0;
            out_data_d  = 8'h00;
            done_d      = 1'b1;
          end else begin
            if (byte_idx_q == BYTE_IW'(BYTES_PER_ELEM - 1)) begin
              byte_idx_d = '0;
              elem_idx_d = elem_idx_q + 1'b1;
            end else begin
              byte_idx_d = byte_idx_q + 1'b1;
            end
            out_data_d = pick_byte(shadow_q, elem_idx_d, byte_idx_d);
          end
        end
      end

      ST_DONE: begin
        out_valid_d = 1'b0;
        out_data_d  = 8'h00;
        done_d      = 1'b1;
        if (!start) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        out_data_d  = 8'h00;
        done_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shadow_q    <= '0;
      elem_idx_q  <= '0;
      byte_idx_q  <= '0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      elem_idx_q  <= elem_idx_d;
      byte_idx_q  <= byte_idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_matrix_output_serializer.sv
// Self-checking bench for matrix_output_serializer: expected byte stream is
// derived from the element values by shifting and masking, then compared per cycle.
module tb_matrix_output_serializer;

  localparam int N_ELEM = 9;
  localparam int ELEM_W = 18;
  localparam int BPE    = 3;

  logic                     clk;
  logic                     rst;
  logic                     start;
  logic [N_ELEM*ELEM_W-1:0] c_flat;
  logic                     out_ready;
  logic [7:0]               out_data;
  logic                     out_valid;
  logic                     done;

  int checks = 0;
  int errors = 0;
  int last_cycles = 0;

  logic [ELEM_W-1:0] c_mem [N_ELEM];
  logic [7:0]        exp_q [$];

  matrix_output_serializer #(
    .N_ELEM(N_ELEM),
    .ELEM_W(ELEM_W),
    .BYTES_PER_ELEM(BPE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .c_flat(c_flat),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: element k contributes bytes (C[k] >> 8j) & FF for j = 0..BPE-1.
  task automatic load_and_start();
    exp_q.delete();
    for (int k = 0; k < N_ELEM; k++) begin
      c_flat[k*ELEM_W +: ELEM_W] = c_mem[k];
      for (int j = 0; j < BPE; j++)
        exp_q.push_back(8'((32'(c_mem[k]) >> (8 * j)) & 32'hFF));
    end
    start = 1'b1;
  endtask

  task automatic randomize_c();
    for (int k = 0; k < N_ELEM; k++) c_mem[k] = ELEM_W'($urandom);
  endtask

  // mode 0: always ready, 1: ready on alternate cycles, 2: random ready
  task automatic collect(input int mode, input int stop_after, input bit corrupt,
                         input bit drop_start);
    int idx;
    int cyc;
    bit fin;
    idx = 0;
    cyc = 0;
    fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 2) == 1);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (corrupt && cyc == 0) c_flat = '1;
      if (drop_start && cyc == 2) start = 1'b0;
      if (idx == exp_q.size()) begin
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
          errors++;
          $display("[TB] FAIL done_entry: done=%b out_valid=%b, required done=1 out_valid=0",
                   done, out_valid);
        end
        fin = 1'b1;
      end else begin
        checks++;
        if (out_valid !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("[TB] FAIL stream_flags byte %0d: out_valid=%b done=%b, required 1/0",
                   idx, out_valid, done);
        end
        checks++;
        if (out_data !== exp_q[idx]) begin
          errors++;
          $display("[TB] FAIL stream_data byte %0d: got %h, required %h",
                   idx, out_data, exp_q[idx]);
        end
        if (out_ready) idx++;
        if (stop_after > 0 && idx == stop_after) fin = 1'b1;
      end
      cyc++;
      if (!fin && cyc > 400) begin
        checks++;
        errors++;
        $display("[TB] FAIL stream_timeout: %0d bytes accepted, required %0d",
                 idx, exp_q.size());
        fin = 1'b1;
      end
    end
    last_cycles = cyc;
  endtask

  task automatic end_stream();
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_return: done=%b out_valid=%b, required 0/0", done, out_valid);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    start     = 1'b1;
    out_ready = 1'b1;
    c_flat    = '1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || done !== 1'b0 || out_data !== 8'h00) begin
        errors++;
        $display("[TB] FAIL reset_outputs: valid=%b done=%b data=%h, required 0 0 00",
                 out_valid, done, out_data);
      end
    end
    rst   = 1'b0;
    start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || done !== 1'b0 || out_data !== 8'h00) begin
        errors++;
        $display("[TB] FAIL reset_idle: valid=%b done=%b data=%h, required 0 0 00",
                 out_valid, done, out_data);
      end
    end
  endtask

  task automatic test_full_stream();
    for (int k = 0; k < N_ELEM; k++)
      c_mem[k] = ELEM_W'(32'h1_0000 * (k % 4) + 32'h0100 * k + k);
    @(negedge clk);
    load_and_start();
    collect(0, 0, 1'b0, 1'b1);
    checks++;
    if (last_cycles !== 28) begin
      errors++;
      $display("[TB] FAIL full_stream_cycles: %0d cycles to done, required 28", last_cycles);
    end
    end_stream();
  endtask

  task automatic test_backpressure();
    randomize_c();
    c_mem[0] = 18'h3_FFFF;
    @(negedge clk);
    load_and_start();
    collect(1, 0, 1'b0, 1'b0);
    checks++;
    if (last_cycles !== 55) begin
      errors++;
      $display("[TB] FAIL backpressure_cycles: %0d cycles to done, required 55", last_cycles);
    end
    end_stream();
  endtask

  task automatic test_random_stream();
    for (int r = 0; r < 3; r++) begin
      randomize_c();
      @(negedge clk);
      load_and_start();
      collect(2, 0, 1'b0, 1'b0);
      end_stream();
    end
  endtask

  task automatic test_capture_isolation();
    randomize_c();
    @(negedge clk);
    load_and_start();
    collect(0, 0, 1'b1, 1'b0);
    end_stream();
  endtask

  task automatic test_reset_midstream();
    randomize_c();
    @(negedge clk);
    load_and_start();
    collect(0, 10, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b0 || out_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL midstream_reset: valid=%b done=%b data=%h, required 0 0 00",
               out_valid, done, out_data);
    end
    randomize_c();
    rst = 1'b0;
    load_and_start();
    collect(0, 0, 1'b0, 1'b0);
    checks++;
    if (last_cycles !== 28) begin
      errors++;
      $display("[TB] FAIL restart_cycles: %0d cycles to done, required 28", last_cycles);
    end
    end_stream();
  endtask

  task automatic test_done_hold();
    randomize_c();
    @(negedge clk);
    load_and_start();
    collect(2, 0, 1'b0, 1'b0);
    repeat (5) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      checks++;
      if (done !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL done_hold: done=%b out_valid=%b, required 1/0", done, out_valid);
      end
    end
    end_stream();
    randomize_c();
    @(negedge clk);
    load_and_start();
    collect(0, 0, 1'b0, 1'b0);
    end_stream();
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    c_flat    = '0;
    test_reset();
    test_full_stream();
    test_backpressure();
    test_random_stream();
    test_capture_isolation();
    test_reset_midstream();
    test_done_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
